// File: rtl/chacha_block_fetch_if.sv
// Memory read port and word stream of the ChaCha20 block fetcher.
// The master side is the fetcher; the slave side is the RAM plus the consumer.
interface chacha_block_fetch_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic [3:0]        mem_byteenable;
  logic              mem_write;
  logic [31:0]       mem_readdata;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_address,
    output mem_chipselect,
    output mem_clken,
    output mem_byteenable,
    output mem_write,
    input  mem_readdata,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  mem_address,
    input  mem_chipselect,
    input  mem_clken,
    input  mem_byteenable,
    input  mem_write,
    output mem_readdata,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/chacha_block_fetch.sv
// Fetches one ChaCha20 state block from RAM and streams it out.
// Define CHACHA_FETCH_BSWAP_EN to byte-reverse each word on capture.
module chacha_block_fetch #(
  parameter int ADDR_W      = 15,
  parameter int BLOCK_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  chacha_block_fetch_if.master bus
);

  localparam int CW = $clog2(BLOCK_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     issued_q;
  logic [CW-1:0]     beat_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic              done_q;
  logic [31:0]       buf_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  logic        accept;
  logic        issue;
  logic        push;
  logic        pop;
  logic        last_beat;
  logic        last_issue;
  logic [2:0]  occ;
  logic [31:0] rd_word;

`ifdef CHACHA_FETCH_BSWAP_EN
  assign rd_word = {bus.mem_readdata[7:0],
                    bus.mem_readdata[15:8],
                    bus.mem_readdata[23:16],
                    bus.mem_readdata[31:24]};
`else
  assign rd_word = bus.mem_readdata;
`endif

  // done_q marks the cycle just after the last beat; start is ignored there
  assign accept     = (state_q == IDLE) && start && !done_q;
  assign push       = inflight_q;
  assign pop        = bus.out_valid && bus.out_ready;
  assign last_beat  = beat_q == CW'(BLOCK_WORDS - 1);
  assign last_issue = issued_q == CW'(BLOCK_WORDS - 1);

  // a word popped this cycle frees its slot before the new read lands
  assign occ   = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (state_q == FETCH)
              && (issued_q < CW'(BLOCK_WORDS))
              && (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (issue && last_issue) state_d = DRAIN;
      DRAIN:   if (pop && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      done_q     <= (state_q == DRAIN) && pop && last_beat;
      if (accept) begin
        addr_q   <= base_addr;
        issued_q <= '0;
        beat_q   <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + 1'b1;
          issued_q <= issued_q + 1'b1;
        end
        if (pop) beat_q <= beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) buf_q[wr_ptr_q] <= rd_word;
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign busy = state_q != IDLE;
  assign done = done_q;

  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_write      = 1'b0;

  assign bus.out_valid = count_q != 2'd0;
  assign bus.out_data  = buf_q[rd_ptr_q];
  assign bus.out_last  = bus.out_valid && last_beat;

endmodule

// File: tb/tb_chacha_block_fetch.sv
// Self-checking bench for chacha_block_fetch: vector table, random blocks,
// restart, mid-block reset and byte-order cases against a RAM/stream model.
module tb_chacha_block_fetch;

  localparam int AW   = 15;
  localparam int BW   = 16;
  localparam int MASK = 32'h7FFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          done;

  chacha_block_fetch_if #(.ADDR_W(AW)) bus ();

  chacha_block_fetch #(
    .ADDR_W(AW),
    .BLOCK_WORDS(BW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:32767];

  always @(posedge clk)
    if (bus.mem_chipselect) bus.mem_readdata <= ram[bus.mem_address];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] w);
`ifdef CHACHA_FETCH_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic load_img(input int base, input int mode);
    for (int k = 0; k < BW; k++)
      ram[(base + k) & MASK] = (mode == 0) ? 32'h6170_0000 + 32'(k)
                             : (mode == 1) ? 32'h5A00_0000 + 32'(k)
                             : $urandom;
  endtask

  int          r_beats, r_cs, r_done, r_first_cs, r_first_valid;
  int          r_done_cyc, r_hs_cyc, r_stab_err, r_occ_err;
  int          r_max_occ, r_post_cs;
  logic        r_busy_at_done;
  logic [31:0] r_first_data, r_last_addr;

  task automatic run_block(input int base, input int pct,
                           input bit restarts, input int abort_beats);
    logic [31:0] expw [BW];
    int          occ;
    int          post;
    bit          cs_p1, cs_p2, hs_p1, hs, pv_stall;
    bit          r3, r15, rdn;
    logic [31:0] pdata;
    for (int k = 0; k < BW; k++) expw[k] = bsw(ram[(base + k) & MASK]);
    r_beats = 0; r_cs = 0; r_done = 0; r_first_cs = -1; r_first_valid = -1;
    r_done_cyc = -1; r_hs_cyc = -1; r_stab_err = 0; r_occ_err = 0;
    r_max_occ = 0; r_post_cs = 0; r_busy_at_done = 1'bx;
    r_first_data = 'x; r_last_addr = 'x;
    occ = 0; post = -1; cs_p1 = 0; cs_p2 = 0; hs_p1 = 0; pv_stall = 0;
    r3 = 0; r15 = 0; rdn = 0; pdata = '0;
    @(posedge clk); #1;
    base_addr = AW'(base);
    start = 1'b1;
    bus.out_ready = ($urandom_range(99) < pct);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // a read issued two cycles ago has landed; last cycle's handshake left
      occ = occ + int'(cs_p2) - int'(hs_p1);
      if (occ > r_max_occ) r_max_occ = occ;
      if (bus.out_valid !== (occ != 0)) r_occ_err++;
      if (pv_stall && (bus.out_valid !== 1'b1 || bus.out_data !== pdata))
        r_stab_err++;
      if (bus.mem_chipselect) begin
        if (r_cs == 0) r_first_cs = cyc;
        if (r_cs < BW) begin
          chk("addr", 32'(bus.mem_address), 32'((base + r_cs) & MASK));
          r_last_addr = 32'(bus.mem_address);
        end
        if (post >= 0) r_post_cs++;
        r_cs++;
      end
      if (bus.out_valid && r_first_valid < 0) r_first_valid = cyc;
      if (done) begin
        r_done++;
        r_done_cyc = cyc;
        r_busy_at_done = busy;
      end
      hs = bus.out_valid && bus.out_ready;
      if (hs) begin
        if (r_beats < BW) begin
          chk("data", bus.out_data, expw[r_beats]);
          chk("last", 32'(bus.out_last), 32'(r_beats == BW - 1));
          if (r_beats == 0) r_first_data = bus.out_data;
        end
        r_beats++;
        if (r_beats == BW) r_hs_cyc = cyc;
      end
      pv_stall = bus.out_valid && !bus.out_ready;
      pdata = bus.out_data;
      cs_p2 = cs_p1;
      cs_p1 = bus.mem_chipselect;
      hs_p1 = hs;
      if (r_done > 0 && post < 0) post = 0;
      if (post >= 0) post++;
      if (post > 10) break;
      if (abort_beats > 0 && r_beats >= abort_beats) break;
      @(posedge clk); #1;
      start = 1'b0;
      if (restarts) begin
        base_addr = 15'h1234;
        if (r_beats == 3 && !r3) begin start = 1'b1; r3 = 1; end
        if (r_beats == 15 && !r15) begin start = 1'b1; r15 = 1; end
        if (r_beats == BW && !rdn) begin start = 1'b1; rdn = 1; end
      end
      bus.out_ready = ($urandom_range(99) < pct);
    end
    start = 1'b0;
  endtask

  task automatic check_block(input int pct);
    chk("beats", 32'(r_beats), 32'(BW));
    chk("cs_count", 32'(r_cs), 32'(BW));
    chk("done_count", 32'(r_done), 32'd1);
    chk("done_timing", 32'(r_done_cyc), 32'(r_hs_cyc + 1));
    chk("busy_at_done", 32'(r_busy_at_done), 32'd0);
    chk("post_cs", 32'(r_post_cs), 32'd0);
    chk("stable_stall", 32'(r_stab_err), 32'd0);
    chk("valid_vs_occ", 32'(r_occ_err), 32'd0);
    chk("occ_le2", 32'(r_max_occ <= 2), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    if (pct >= 100) begin
      chk("lat_cs", 32'(r_first_cs), 32'd1);
      chk("lat_valid", 32'(r_first_valid), 32'd3);
      chk("lat_done", 32'(r_done_cyc), 32'(3 + BW));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cs"}, 32'(bus.mem_chipselect), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_data"}, bus.out_data, 32'd0);
    chk({tag, "_ties"}, {27'd0, bus.mem_clken, bus.mem_byteenable},
        {27'd0, 1'b1, 4'hF});
  endtask

  typedef struct {
    int          base;
    int          pct;
    logic [31:0] exp_first;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{32'h0100, 100, 32'h6170_0000, 32'h010F};
    vecs[1] = '{32'h0100, 30,  32'h6170_0000, 32'h010F};
    vecs[2] = '{32'h7FFF, 100, 32'h6170_0000, 32'h000E};
    vecs[3] = '{32'h7FFF, 50,  32'h6170_0000, 32'h000E};
    vecs[4] = '{32'h0000, 70,  32'h6170_0000, 32'h000F};

    for (int a = 0; a < 32768; a++) ram[a] = '0;
    bus.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    chk("rst_write", 32'(bus.mem_write), 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      load_img(vecs[i].base, 0);
      run_block(vecs[i].base, vecs[i].pct, 1'b0, 0);
      check_block(vecs[i].pct);
      chk("first_word", r_first_data, bsw(vecs[i].exp_first));
      chk("last_addr", r_last_addr, vecs[i].exp_last_addr);
    end

    for (int n = 0; n < 4; n++) begin
      int b;
      int p;
      b = $urandom_range(0, 32767);
      p = $urandom_range(20, 100);
      load_img(b, 2);
      run_block(b, p, 1'b0, 0);
      check_block(p);
    end

    load_img(32'h0100, 0);
    run_block(32'h0100, 60, 1'b1, 0);
    check_block(60);

    load_img(32'h0500, 0);
    run_block(32'h0500, 100, 1'b0, 5);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    chk("midrst_hold_cs", 32'(bus.mem_chipselect), 32'd0);
    chk("midrst_hold_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_no_done", 32'(r_done + int'(done)), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    load_img(32'h0200, 1);
    run_block(32'h0200, 70, 1'b0, 0);
    check_block(70);
    chk("post_rst_first", r_first_data, bsw(32'h5A00_0000));

    load_img(32'h0300, 2);
    ram[15'h0300] = 32'h1122_3344;
    run_block(32'h0300, 100, 1'b0, 0);
    check_block(100);
`ifdef CHACHA_FETCH_BSWAP_EN
    chk("byte_order", r_first_data, 32'h4433_2211);
`else
    chk("byte_order", r_first_data, 32'h1122_3344);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
